// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache #(
  parameter int          INDEX_WIDTH = 6,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] new_inst_addr,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TW = 30 - INDEX_WIDTH;
  typedef enum logic {IDLE, MISS} state_t;
  state_t                 state_q;
  logic                   pend_q;
  logic [31:0]            pend_addr_q;
  logic [31:0]            data_q [LINES];
  logic [TW-1:0]          tag_q [LINES];
  logic [LINES-1:0]       valid_q;
  logic                   req_v, hit, fill;
  logic [31:0]            req_addr;
  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  // pick the request (pending restart beats decoder) and look it up
  always_comb begin
    req_v    = pend_q | (if_enable & ~inst_ready);
    req_addr = pend_q ? pend_addr_q : if_addr;
    req_idx  = req_addr[INDEX_WIDTH+1:2];
    fill_idx = mem_addr[INDEX_WIDTH+1:2];
    hit      = valid_q[req_idx] && (tag_q[req_idx] == req_addr[31:INDEX_WIDTH+2]);
    fill     = rdy_in && (state_q == MISS) && mem_ready;
  end
  // line storage; a refill lands even when a flush arrives in the same cycle
  always_ff @(posedge clk_in) begin
    if (!rst_in && fill) begin
      data_q[fill_idx] <= mem_data;
      tag_q[fill_idx]  <= mem_addr[31:INDEX_WIDTH+2];
    end
  end
  // control FSM with registered decoder and memctrl outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pend_q      <= 1'b1;
      pend_addr_q <= RESET_PC;
      valid_q     <= '0;
      inst_ready  <= 1'b0;
      inst        <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else if (rdy_in) begin
      if (fill) valid_q[fill_idx] <= 1'b1;
      if (clear) begin
        state_q     <= IDLE;
        pend_q      <= 1'b1;
        pend_addr_q <= new_inst_addr;
        inst_ready  <= 1'b0;
        mem_req     <= 1'b0;
      end else if (state_q == IDLE) begin
        inst_ready <= req_v && hit;
        if (req_v) begin
          pend_q <= 1'b0;
          if (hit) inst <= data_q[req_idx];
          else begin
            mem_req  <= 1'b1;
            mem_addr <= req_addr;
            state_q  <= MISS;
          end
        end
      end else if (mem_ready) begin
        inst_ready <= 1'b1;
        inst       <= mem_data;
        mem_req    <= 1'b0;
        state_q    <= IDLE;
      end
    end
  end
`ifdef ICACHE_STATS_EN
  // count each request as it resolves in IDLE
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in && !clear && state_q == IDLE && req_v) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
